// File: rtl/pio_pkg.sv
// Shared definitions for the PIO FIFO pair: mode encodings and per-direction capacity.
package pio_pkg;

    typedef logic [1:0] mode_t;

    // Encoding is {join_tx, join_rx}; 2'b11 is treated as normal.
    localparam mode_t MODE_NORMAL = 2'b00;
    localparam mode_t MODE_JTX    = 2'b10;
    localparam mode_t MODE_JRX    = 2'b01;

    typedef enum logic {
        DirTx = 1'b0,
        DirRx = 1'b1
    } dir_e;

    // Capacity of one direction in units of DEPTH: 0, 1 or 2.
    function automatic int unsigned cap_of(mode_t mode, dir_e dir);
        int unsigned units;
        units = 1;
        if (mode == MODE_JTX) begin
            units = (dir == DirTx) ? 2 : 0;
        end else if (mode == MODE_JRX) begin
            units = (dir == DirRx) ? 2 : 0;
        end
        return units;
    endfunction

endpackage

// File: rtl/pio_fifo_ring.sv
// Ring-buffer FIFO with 2*DEPTH entries of storage and a runtime capacity (0, DEPTH or 2*DEPTH).
// Head is first-word-fall-through and reads as 0 while empty.
module pio_fifo_ring #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned LW    = $clog2(2 * DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic [LW-1:0]    capacity,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pull,
    output logic [LW-1:0]    level,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned PW = LW - 1;

    logic [WIDTH-1:0] mem_q [2*DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push, do_pull;

    // Pointers wrap at the current capacity, not at the storage size.
    function automatic logic [PW-1:0] ptr_inc(logic [PW-1:0] ptr, logic [LW-1:0] cap);
        logic [LW-1:0] nxt;
        nxt = {1'b0, ptr} + LW'(1);
        return (nxt >= cap) ? '0 : nxt[PW-1:0];
    endfunction

    assign full    = (level_q >= capacity);
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign head    = empty ? '0 : mem_q[rd_ptr_q];
    assign do_push = push & ~full & ~clear;
    assign do_pull = pull & ~empty & ~clear;

    // Next pointer/level state; clear discards both strobes.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q, capacity);
            if (do_pull) rd_ptr_d = ptr_inc(rd_ptr_q, capacity);
            level_d = level_q + LW'(do_push) - LW'(do_pull);
        end
    end

    // Pointer and level registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/pio_fifo_pair.sv
// TX/RX FIFO pair for one PIO state machine: mode tracking with flush on mode change,
// sticky overflow/underflow flags and the level-threshold status bit.
module pio_fifo_pair
    import pio_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned LW    = $clog2(2 * DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             join_tx,
    input  logic             join_rx,
    input  logic             flush,
    input  logic             tx_push,
    input  logic [WIDTH-1:0] tx_wdata,
    output logic             tx_full,
    output logic [LW-1:0]    tx_level,
    input  logic             m_pull,
    output logic [WIDTH-1:0] m_rdata,
    output logic             tx_empty,
    input  logic             m_push,
    input  logic [WIDTH-1:0] m_wdata,
    output logic             rx_full,
    input  logic             rx_pull,
    output logic [WIDTH-1:0] rx_rdata,
    output logic             rx_empty,
    output logic [LW-1:0]    rx_level,
    input  logic             status_sel,
    input  logic [LW-1:0]    status_n,
    output logic             status,
    input  logic [1:0]       err_clr,
    output logic             tx_over,
    output logic             rx_under
);

    mode_t         mode_q, mode_in;
    logic          flush_now;
    logic [LW-1:0] tx_cap, rx_cap;
    logic          tx_over_q, tx_over_d;
    logic          rx_under_q, rx_under_d;

    assign mode_in   = {join_tx, join_rx};
    assign flush_now = flush | (mode_in != mode_q);
    assign tx_cap    = LW'(cap_of(mode_q, DirTx) * DEPTH);
    assign rx_cap    = LW'(cap_of(mode_q, DirRx) * DEPTH);

    pio_fifo_ring #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .LW    (LW)
    ) u_tx (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (flush_now),
        .capacity (tx_cap),
        .push     (tx_push),
        .wdata    (tx_wdata),
        .pull     (m_pull),
        .level    (tx_level),
        .full     (tx_full),
        .empty    (tx_empty),
        .head     (m_rdata)
    );

    pio_fifo_ring #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .LW    (LW)
    ) u_rx (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (flush_now),
        .capacity (rx_cap),
        .push     (m_push),
        .wdata    (m_wdata),
        .pull     (rx_pull),
        .level    (rx_level),
        .full     (rx_full),
        .empty    (rx_empty),
        .head     (rx_rdata)
    );

    // Sticky flags: set by dropped host strobes outside a flush; clear wins over set.
    always_comb begin
        tx_over_d  = tx_over_q;
        rx_under_d = rx_under_q;
        if (!flush_now && tx_push && tx_full)  tx_over_d  = 1'b1;
        if (!flush_now && rx_pull && rx_empty) rx_under_d = 1'b1;
        if (err_clr[0]) tx_over_d  = 1'b0;
        if (err_clr[1]) rx_under_d = 1'b0;
    end

    // Mode copy and flag registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q     <= MODE_NORMAL;
            tx_over_q  <= 1'b0;
            rx_under_q <= 1'b0;
        end else begin
            mode_q     <= mode_in;
            tx_over_q  <= tx_over_d;
            rx_under_q <= rx_under_d;
        end
    end

    assign tx_over  = tx_over_q;
    assign rx_under = rx_under_q;
    assign status   = ((status_sel ? rx_level : tx_level) < status_n);

endmodule

// File: tb/tb_pio_fifo_pair.sv
// Randomised and directed bench for pio_fifo_pair against a queue-based reference model.
module tb_pio_fifo_pair;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LW    = $clog2(2 * DEPTH) + 1;

    logic             clk = 1'b0;
    logic             reset_n = 1'b1;
    logic             join_tx, join_rx, flush;
    logic             tx_push, m_pull, m_push, rx_pull;
    logic [WIDTH-1:0] tx_wdata, m_wdata;
    logic             tx_full, tx_empty, rx_full, rx_empty;
    logic [LW-1:0]    tx_level, rx_level;
    logic [WIDTH-1:0] m_rdata, rx_rdata;
    logic             status_sel;
    logic [LW-1:0]    status_n;
    logic             status;
    logic [1:0]       err_clr;
    logic             tx_over, rx_under;

    always #5 clk = ~clk;

    pio_fifo_pair #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .LW    (LW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .join_tx    (join_tx),
        .join_rx    (join_rx),
        .flush      (flush),
        .tx_push    (tx_push),
        .tx_wdata   (tx_wdata),
        .tx_full    (tx_full),
        .tx_level   (tx_level),
        .m_pull     (m_pull),
        .m_rdata    (m_rdata),
        .tx_empty   (tx_empty),
        .m_push     (m_push),
        .m_wdata    (m_wdata),
        .rx_full    (rx_full),
        .rx_pull    (rx_pull),
        .rx_rdata   (rx_rdata),
        .rx_empty   (rx_empty),
        .rx_level   (rx_level),
        .status_sel (status_sel),
        .status_n   (status_n),
        .status     (status),
        .err_clr    (err_clr),
        .tx_over    (tx_over),
        .rx_under   (rx_under)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    logic [WIDTH-1:0] tx_m[$];
    logic [WIDTH-1:0] rx_m[$];
    logic [1:0]       m_mode;
    logic             m_over, m_under;

    function automatic int cap_model(logic [1:0] mode, bit is_rx);
        if (mode == 2'b10) return is_rx ? 0 : 2 * DEPTH;
        if (mode == 2'b01) return is_rx ? 2 * DEPTH : 0;
        return DEPTH;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        tx_m.delete();
        rx_m.delete();
        m_mode  = 2'b00;
        m_over  = 1'b0;
        m_under = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        bit fl;
        int ctx, crx;
        bit t_full, t_empty, r_full, r_empty;
        if (!reset_n) return;
        fl  = flush || ({join_tx, join_rx} != m_mode);
        ctx = cap_model(m_mode, 1'b0);
        crx = cap_model(m_mode, 1'b1);
        if (fl) begin
            tx_m.delete();
            rx_m.delete();
            m_mode = {join_tx, join_rx};
        end else begin
            t_full  = (tx_m.size() >= ctx);
            t_empty = (tx_m.size() == 0);
            r_full  = (rx_m.size() >= crx);
            r_empty = (rx_m.size() == 0);
            if (m_pull && !t_empty) void'(tx_m.pop_front());
            if (tx_push) begin
                if (t_full) m_over = 1'b1;
                else tx_m.push_back(tx_wdata);
            end
            if (rx_pull) begin
                if (r_empty) m_under = 1'b1;
                else void'(rx_m.pop_front());
            end
            if (m_push && !r_full) rx_m.push_back(m_wdata);
        end
        if (err_clr[0]) m_over = 1'b0;
        if (err_clr[1]) m_under = 1'b0;
    endtask

    task automatic compare_all();
        int tl, rl, ctx, crx;
        logic [LW-1:0]    sl;
        logic [WIDTH-1:0] th, rh;
        tl  = tx_m.size();
        rl  = rx_m.size();
        ctx = cap_model(m_mode, 1'b0);
        crx = cap_model(m_mode, 1'b1);
        th  = (tl != 0) ? tx_m[0] : '0;
        rh  = (rl != 0) ? rx_m[0] : '0;
        sl  = status_sel ? LW'(rl) : LW'(tl);
        chk("tx_level", tx_level, tl);
        chk("tx_full", tx_full, tl >= ctx);
        chk("tx_empty", tx_empty, tl == 0);
        chk("m_rdata", m_rdata, th);
        chk("rx_level", rx_level, rl);
        chk("rx_full", rx_full, rl >= crx);
        chk("rx_empty", rx_empty, rl == 0);
        chk("rx_rdata", rx_rdata, rh);
        chk("status", status, sl < status_n);
        chk("tx_over", tx_over, m_over);
        chk("rx_under", rx_under, m_under);
    endtask

    // One clock: model follows the edge, outputs are compared on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
        #2;
    endtask

    task automatic idle();
        tx_push = 1'b0;
        m_pull  = 1'b0;
        m_push  = 1'b0;
        rx_pull = 1'b0;
        flush   = 1'b0;
        err_clr = 2'b00;
    endtask

    initial begin
        join_tx    = 1'b0;
        join_rx    = 1'b0;
        idle();
        tx_wdata   = '0;
        m_wdata    = '0;
        status_sel = 1'b0;
        status_n   = LW'(2);
        model_reset();
        #1 reset_n = 1'b0;
        #2;
        // Reset values, before any clock edge.
        chk("rst_tx_level", tx_level, 0);
        chk("rst_rx_level", rx_level, 0);
        chk("rst_tx_empty", tx_empty, 1);
        chk("rst_rx_empty", rx_empty, 1);
        chk("rst_tx_full", tx_full, 0);
        chk("rst_rx_full", rx_full, 0);
        chk("rst_m_rdata", m_rdata, 0);
        chk("rst_rx_rdata", rx_rdata, 0);
        chk("rst_flags", {tx_over, rx_under}, 0);
        chk("rst_status_n2", status, 1);
        status_n = '0;
        #1 chk("rst_status_n0", status, 0);
        status_n = LW'(2);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Normal mode: overflow on the fifth push, then ordered drain.
        for (int i = 0; i < 5; i++) begin
            tx_push  = 1'b1;
            tx_wdata = 32'h11 + i;
            tick();
            if (i == 3) chk("p1_full_after4", tx_full, 1);
        end
        idle();
        chk("p1_level", tx_level, 4);
        chk("p1_over", tx_over, 1);
        m_pull = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("p1_pull_order", m_rdata, 32'h11 + i);
            tick();
        end
        idle();
        chk("p1_empty", tx_empty, 1);
        err_clr = 2'b01;
        tick();
        idle();

        // TX joined: 8 entries, RX capacity 0.
        join_tx = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            tx_push  = 1'b1;
            tx_wdata = 32'h100 + i;
            tick();
        end
        idle();
        chk("p2_tx_level", tx_level, 8);
        chk("p2_tx_full", tx_full, 1);
        chk("p2_rx_full", rx_full, 1);
        chk("p2_rx_empty", rx_empty, 1);
        chk("p2_over_pre", tx_over, 0);
        tx_push  = 1'b1;
        tx_wdata = 32'h1ff;
        tick();
        idle();
        chk("p2_over", tx_over, 1);
        m_push  = 1'b1;
        m_wdata = 32'hdead;
        tick();
        idle();
        chk("p2_rx_level", rx_level, 0);
        join_tx = 1'b0;
        err_clr = 2'b01;
        tick();
        idle();
        chk("p2_flush_level", tx_level, 0);

        // Simultaneous push/pull on both directions.
        tx_push = 1'b1;
        tx_wdata = 32'h21;
        tick();
        tx_wdata = 32'h22;
        tick();
        tx_wdata = 32'h23;
        m_pull   = 1'b1;
        tick();
        idle();
        chk("p3_tx_level", tx_level, 2);
        chk("p3_head", m_rdata, 32'h22);
        m_push  = 1'b1;
        m_wdata = 32'h55;
        rx_pull = 1'b1;
        tick();
        idle();
        chk("p3_rx_level", rx_level, 1);
        chk("p3_under", rx_under, 1);
        chk("p3_rx_head", rx_rdata, 32'h55);
        err_clr = 2'b10;
        tick();
        idle();
        chk("p3_under_clr", rx_under, 0);

        // Mode change flushes and discards that cycle's strobes.
        tx_push  = 1'b1;
        tx_wdata = 32'h24;
        tick();
        idle();
        m_push  = 1'b1;
        m_wdata = 32'h56;
        tick();
        idle();
        chk("p4_tx3", tx_level, 3);
        chk("p4_rx2", rx_level, 2);
        join_rx = 1'b1;
        tx_push = 1'b1;
        rx_pull = 1'b1;
        m_push  = 1'b1;
        tick();
        idle();
        chk("p4_tx0", tx_level, 0);
        chk("p4_rx0", rx_level, 0);
        chk("p4_flags", {tx_over, rx_under}, 0);
        chk("p4_tx_full", tx_full, 1);
        chk("p4_tx_empty", tx_empty, 1);
        for (int i = 0; i < 9; i++) begin
            m_push  = 1'b1;
            m_wdata = 32'h300 + i;
            tick();
        end
        idle();
        chk("p4_rx8", rx_level, 8);
        chk("p4_rx_full", rx_full, 1);
        rx_pull = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("p4_rx_order", rx_rdata, 32'h300 + i);
            tick();
        end
        tick();
        idle();
        chk("p4_under", rx_under, 1);
        err_clr = 2'b10;
        tick();
        idle();

        // Status threshold on TX then RX level.
        join_rx    = 1'b0;
        tick();
        status_sel = 1'b0;
        status_n   = LW'(2);
        #1;
        for (int l = 0; l < 4; l++) begin
            chk("p5_status_tx", status, l < 2);
            tx_push  = 1'b1;
            tx_wdata = 32'h40 + l;
            tick();
            tx_push  = 1'b0;
        end
        status_sel = 1'b1;
        #1;
        for (int l = 0; l < 3; l++) begin
            chk("p5_status_rx", status, l < 2);
            m_push  = 1'b1;
            m_wdata = 32'h50 + l;
            tick();
            m_push  = 1'b0;
        end
        idle();

        // Random traffic with occasional flushes, mode changes and flag clears.
        for (int c = 0; c < 3000; c++) begin
            int pct;
            pct        = (((c / 200) % 2) != 0) ? 70 : 30;
            tx_push    = ($urandom_range(0, 99) < pct);
            m_push     = ($urandom_range(0, 99) < pct);
            m_pull     = ($urandom_range(0, 99) < (100 - pct));
            rx_pull    = ($urandom_range(0, 99) < (100 - pct));
            flush      = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 127) == 0) join_tx = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 127) == 0) join_rx = 1'($urandom_range(0, 1));
            err_clr    = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            status_sel = 1'($urandom_range(0, 1));
            status_n   = LW'($urandom_range(0, 15));
            tx_wdata   = $urandom;
            m_wdata    = $urandom;
            tick();
        end
        idle();

        // Asynchronous reset in the middle of traffic.
        join_tx = 1'b0;
        join_rx = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            tx_push  = 1'b1;
            m_push   = 1'b1;
            tx_wdata = 32'ha0 + i;
            m_wdata  = 32'hb0 + i;
            tick();
        end
        idle();
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("ar_tx_level", tx_level, 0);
        chk("ar_tx_empty", tx_empty, 1);
        chk("ar_m_rdata", m_rdata, 0);
        chk("ar_rx_level", rx_level, 0);
        chk("ar_rx_empty", rx_empty, 1);
        chk("ar_rx_rdata", rx_rdata, 0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        tx_push  = 1'b1;
        tx_wdata = 32'hc1;
        tick();
        idle();
        chk("ar_resume_head", m_rdata, 32'hc1);
        chk("ar_resume_level", tx_level, 1);
        m_pull = 1'b1;
        tick();
        idle();
        chk("ar_resume_empty", tx_empty, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
